// File: rtl/text_buffer_pkg.sv
// Shared constants and types for the character-cell text buffer:
// font code width, host control codes and the buffer FSM states.
package text_buffer_pkg;

  localparam int FONT_WIDTH = 8;

  localparam logic [FONT_WIDTH-1:0] CODE_BS    = 8'h08;
  localparam logic [FONT_WIDTH-1:0] CODE_LF    = 8'h0A;
  localparam logic [FONT_WIDTH-1:0] CODE_FF    = 8'h0C;
  localparam logic [FONT_WIDTH-1:0] CODE_CR    = 8'h0D;
  localparam logic [FONT_WIDTH-1:0] CODE_SPACE = 8'h20;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port text RAM: one write port, one registered read port on the
// same clock. A read of the cell being written returns the previous contents.
module text_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Character-cell text buffer: clears itself after reset or form feed, takes
// host codes one per cycle through a cursor, and serves the display each cycle.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int                    COLS  = 80,
  parameter int                    ROWS  = 60,
  parameter logic [FONT_WIDTH-1:0] BLANK = CODE_SPACE
) (
  input  logic                  px_clk,
  input  logic                  resetn,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  output logic [FONT_WIDTH-1:0] character,
  input  logic [FONT_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [6:0]            cursor_x,
  output logic [5:0]            cursor_y
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  state_t                  state;
  logic [AW-1:0]           clr_addr;
  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [FONT_WIDTH-1:0]   ram_wdata;
  logic [AW-1:0]           rd_addr;
  logic [FONT_WIDTH-1:0]   ram_q;
  logic                    off_screen;
  logic                    blank_p1;
  logic [AW-1:0]           cursor_addr;
  logic                    printable;

  function automatic logic [5:0] next_row(input logic [5:0] row);
    return (row == 6'(ROWS - 1)) ? 6'd0 : row + 6'd1;
  endfunction

  assign printable   = (wr_data >= CODE_SPACE);
  assign cursor_addr = AW'(cursor_y) * AW'(COLS) + AW'(cursor_x);

  always_ff @(posedge px_clk) begin
    if (!resetn) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      wr_ready <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_addr == AW'(CELLS - 1)) begin
            state    <= ST_IDLE;
            wr_ready <= 1'b1;
            clr_addr <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (wr_valid) begin
            case (wr_data)
              CODE_FF: begin
                state    <= ST_CLEAR;
                wr_ready <= 1'b0;
                clr_addr <= '0;
                cursor_x <= '0;
                cursor_y <= '0;
              end
              CODE_LF: begin
                cursor_x <= '0;
                cursor_y <= next_row(cursor_y);
              end
              CODE_CR: cursor_x <= '0;
              CODE_BS: if (cursor_x != 7'd0) cursor_x <= cursor_x - 7'd1;
              default: begin
                // remaining control codes fall through here and are dropped
                if (printable) begin
                  if (cursor_x == 7'(COLS - 1)) begin
                    cursor_x <= '0;
                    cursor_y <= next_row(cursor_y);
                  end else begin
                    cursor_x <= cursor_x + 7'd1;
                  end
                end
              end
            endcase
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr;
    ram_wdata = BLANK;
    if (resetn) begin
      if (state == ST_CLEAR) begin
        ram_we = 1'b1;
      end else if (wr_valid && printable) begin
        ram_we    = 1'b1;
        ram_waddr = cursor_addr;
        ram_wdata = wr_data;
      end
    end
  end

  // stage p0: display address from the pixel position
  assign off_screen = (pos_x >= 10'(COLS * 8)) || (pos_y >= 10'(ROWS * 8));
  assign rd_addr    = off_screen ? '0
                                 : AW'(pos_y[8:3]) * AW'(COLS) + AW'(pos_x[9:3]);

  text_ram #(
    .DEPTH(CELLS),
    .AW   (AW),
    .DW   (FONT_WIDTH)
  ) u_ram (
    .clk  (px_clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(rd_addr),
    .q    (ram_q)
  );

  // stage p1: RAM data is registered; substitute BLANK off-screen or in reset
  always_ff @(posedge px_clk) begin
    if (!resetn) blank_p1 <= 1'b1;
    else         blank_p1 <= off_screen;
  end

  assign character = blank_p1 ? BLANK : ram_q;

endmodule

// File: tb/tb_text_buffer.sv
// Randomized self-checking bench for text_buffer with a cell-array model of
// the screen and cursor, plus directed scenarios with literal expectations.
module tb_text_buffer;
  import text_buffer_pkg::*;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;

  logic       px_clk   = 1'b0;
  logic       resetn   = 1'b0;
  logic [9:0] pos_x    = '0;
  logic [9:0] pos_y    = '0;
  logic [7:0] wr_data  = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] character;
  logic       wr_ready;
  logic [6:0] cursor_x;
  logic [5:0] cursor_y;

  always #5 px_clk = ~px_clk;

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .px_clk   (px_clk),
    .resetn   (resetn),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .character(character),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Screen model: what each cell holds, where the cursor is, whether a clear runs.
  logic [7:0] m_mem [CELLS];
  bit         m_started  = 1'b0;
  bit         m_known    = 1'b0;
  bit         m_clearing = 1'b0;
  bit         m_ready    = 1'b0;
  bit         m_chk      = 1'b0;
  int         m_idx      = 0;
  int         m_cx       = 0;
  int         m_cy       = 0;
  logic [7:0] m_char     = 8'h20;

  always @(posedge px_clk) begin
    if (!resetn) begin
      m_started  = 1'b1;
      m_clearing = 1'b1;
      m_idx      = 0;
      m_cx       = 0;
      m_cy       = 0;
      m_ready    = 1'b0;
      m_char     = 8'h20;
      m_chk      = 1'b1;
    end else if (m_started) begin
      if (pos_x >= 640 || pos_y >= 480) begin
        m_char = 8'h20;
        m_chk  = 1'b1;
      end else begin
        m_char = m_mem[(int'(pos_y) / 8) * COLS + int'(pos_x) / 8];
        m_chk  = m_known;
      end
      if (m_clearing) begin
        m_mem[m_idx] = 8'h20;
        if (m_idx == CELLS - 1) begin
          m_clearing = 1'b0;
          m_known    = 1'b1;
          m_cx       = 0;
          m_cy       = 0;
        end else begin
          m_idx++;
        end
      end else if (wr_valid) begin
        if (wr_data >= 8'h20) begin
          m_mem[m_cy * COLS + m_cx] = wr_data;
          m_cx++;
          if (m_cx == COLS) begin
            m_cx = 0;
            m_cy = (m_cy + 1) % ROWS;
          end
        end else if (wr_data == 8'h0A) begin
          m_cx = 0;
          m_cy = (m_cy + 1) % ROWS;
        end else if (wr_data == 8'h0D) begin
          m_cx = 0;
        end else if (wr_data == 8'h08) begin
          if (m_cx > 0) m_cx--;
        end else if (wr_data == 8'h0C) begin
          m_clearing = 1'b1;
          m_idx      = 0;
          m_cx       = 0;
          m_cy       = 0;
        end
      end
      m_ready = !m_clearing;
    end
  end

  always @(negedge px_clk) begin
    if (m_started) begin
      chk("wr_ready", 32'(wr_ready), 32'(m_ready));
      chk("cursor_x", 32'(cursor_x), 32'(m_cx));
      chk("cursor_y", 32'(cursor_y), 32'(m_cy));
      if (m_chk) chk("character", 32'(character), 32'(m_char));
    end
  end

  task automatic step();
    @(posedge px_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    wr_data  = c;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    while (!wr_ready && n < 10000) begin
      n++;
      step();
    end
  endtask

  task automatic show(input int x, input int y);
    pos_x = 10'(x);
    pos_y = 10'(y);
    step();
  endtask

  int n;
  int r;

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge px_clk);
    #1;
    chk("reset_ready", 32'(wr_ready), 32'd0);
    chk("reset_char", 32'(character), 32'h20);
    chk("reset_cursor", {25'd0, cursor_x}, 32'd0);
    resetn = 1'b1;

    count_clear(n);
    chk("first_clear_len", n, 32'd4800);

    for (int row = 0; row < ROWS; row++) begin
      for (int col = 0; col < COLS; col++) begin
        show(col * 8 + int'($urandom_range(7)), row * 8 + int'($urandom_range(7)));
        chk("sweep_blank", 32'(character), 32'h20);
      end
    end

    send(8'h41);
    send(8'h42);
    chk("ab_cursor_x", 32'(cursor_x), 32'd2);
    chk("ab_cursor_y", 32'(cursor_y), 32'd0);
    show(0, 0);
    chk("cell0_A", 32'(character), 32'h41);
    show(8, 0);
    chk("cell1_B", 32'(character), 32'h42);

    for (int i = 2; i < CELLS - 1; i++) send(8'(8'h21 + i % 90));
    chk("fill_cursor_x", 32'(cursor_x), 32'd79);
    chk("fill_cursor_y", 32'(cursor_y), 32'd59);
    send(8'h41);
    chk("wrap_cursor_x", 32'(cursor_x), 32'd0);
    chk("wrap_cursor_y", 32'(cursor_y), 32'd0);
    show(639, 479);
    chk("cell4799", 32'(character), 32'h41);
    send(8'h0A);
    chk("lf_cursor", {cursor_y, cursor_x}, {19'd0, 6'd1, 7'd0});
    send(8'h0D);
    chk("cr_cursor", {cursor_y, cursor_x}, {19'd0, 6'd1, 7'd0});
    send(8'h08);
    chk("bs0_cursor", {cursor_y, cursor_x}, {19'd0, 6'd1, 7'd0});
    send(8'h78);
    send(8'h08);
    chk("bs1_cursor", {cursor_y, cursor_x}, {19'd0, 6'd1, 7'd0});

    show(640, 0);
    chk("offscreen_x", 32'(character), 32'h20);
    show(0, 480);
    chk("offscreen_y", 32'(character), 32'h20);

    wr_data  = 8'h0C;
    wr_valid = 1'b1;
    step();
    wr_data = 8'h5A;
    count_clear(n);
    chk("ff_clear_len", n, 32'd4800);
    chk("ff_cursor", {cursor_y, cursor_x}, 32'd0);
    wr_valid = 1'b0;

    send(8'h0C);
    repeat (2000) @(posedge px_clk);
    #1;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    count_clear(n);
    chk("restart_clear_len", n, 32'd4800);

    for (int i = 0; i < 3000; i++) begin
      wr_valid = ($urandom_range(2) != 0);
      r = int'($urandom_range(99));
      if (r < 80)      wr_data = 8'(8'h20 + $urandom_range(94));
      else if (r < 88) wr_data = 8'h0A;
      else if (r < 92) wr_data = 8'h0D;
      else if (r < 97) wr_data = 8'h08;
      else             wr_data = 8'(1 + $urandom_range(6));
      if ($urandom_range(3) == 0) begin
        pos_x = 10'(m_cx * 8 + int'($urandom_range(7)));
        pos_y = 10'(m_cy * 8 + int'($urandom_range(7)));
      end else begin
        pos_x = 10'($urandom_range(799));
        pos_y = 10'($urandom_range(524));
      end
      step();
    end
    wr_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish before 5000000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns (8-px cells across 640 px).
REQ-002 SHALL have parameter ROWS, default 60, meaning text rows (8-px cells down 480 px).
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning the code written by clear and output for off-screen positions.
REQ-004 SHALL have port px_clk  input  1  pixel clock; the only clock.
REQ-005 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pos_x  input  10  X screen position from the sync generator.
REQ-007 SHALL have port pos_y  input  10  Y screen position from the sync generator.
REQ-008 SHALL have port character  output  `FONT_WIDTH  character code at (pos_x, pos_y), feeding the font stage.
REQ-009 SHALL have port wr_data  input  `FONT_WIDTH  character or control code from the host.
REQ-010 SHALL have port wr_valid  input  1  host asserts while wr_data is valid.
REQ-011 SHALL have port wr_ready  output  1  block can accept wr_data this cycle.
REQ-012 SHALL have port cursor_x  output  7  current cursor column.
REQ-013 SHALL have port cursor_y  output  6  current cursor row.

Function
REQ-014 SHALL hold a COLS*ROWS x `FONT_WIDTH text RAM with one registered read port (display) and one write port (host/clear), both on px_clk.
REQ-015 Read address SHALL be pos_y[8:3]*COLS + pos_x[9:3]; character SHALL be registered, valid exactly 1 cycle after pos_x/pos_y are presented.
REQ-016 When pos_x >= COLS*8 or pos_y >= ROWS*8, character SHALL be BLANK one cycle later.
REQ-017 Display reads SHALL proceed every cycle regardless of write activity or FSM state.
REQ-018 FSM states SHALL be: CLEAR (write BLANK at address 0..COLS*ROWS-1, one per cycle) and IDLE (accept host codes).
REQ-019 CLEAR -> IDLE SHALL occur the cycle after address COLS*ROWS-1 is written; cursor SHALL then be (0,0).
REQ-020 wr_ready SHALL be 1 only in IDLE; a transfer SHALL occur when wr_valid && wr_ready at a px_clk edge.
REQ-021 Printable code (>= 0x20) SHALL be written at cursor_y*COLS + cursor_x, then cursor_x increments.
REQ-022 At cursor_x == COLS-1 a printable write SHALL set cursor_x = 0 and advance cursor_y.
REQ-023 Code 0x0A (LF) SHALL set cursor_x = 0 and advance cursor_y, with no RAM write.
REQ-024 Code 0x0D (CR) SHALL set cursor_x = 0, with no RAM write.
REQ-025 Code 0x08 (BS) SHALL decrement cursor_x if nonzero, with no erase and no row change.
REQ-026 Code 0x0C (FF) SHALL enter CLEAR, dropping wr_ready the next cycle.
REQ-027 Other codes < 0x20 SHALL be accepted and ignored.
REQ-028 Advancing cursor_y from ROWS-1 SHALL wrap it to 0; there is no scrolling.
REQ-029 Each accepted code SHALL take effect in one cycle, sustaining one code per cycle in IDLE.
REQ-030 A host write to the cell being displayed in the same cycle SHALL return the old value; a read-during-write returning the old value is required.

Reset
REQ-031 While resetn == 0 at a px_clk edge: state = CLEAR, clear address = 0, cursor = (0,0), wr_ready = 0, character = BLANK.
REQ-032 Reset asserted mid-CLEAR or mid-stream SHALL restart the clear from address 0; no partial state SHALL survive.
REQ-033 RAM contents SHALL NOT be guaranteed until the first CLEAR completes; until then the display may show stale data.

Structure
REQ-034 `FONT_WIDTH and the control-code constants (LF, CR, BS, FF, BLANK) SHALL live in the shared const.vh.
REQ-035 The text RAM SHALL be a sub-module, text_ram (simple dual-port, registered read, BRAM-inferable); FSM, cursor and address arithmetic SHALL stay in text_buffer.
REQ-036 Total pixel latency to the font output SHALL be 2 cycles (this block 1, font 1); the top level SHALL delay sync/blank by 2 cycles.

Verification
REQ-037 Reset, then hold resetn=1 -> wr_ready=0 for exactly 4800 cycles, then 1; sweeping all positions returns 0x20 everywhere.
REQ-038 Send 'A'(0x41), 'B'(0x42) -> cursor (2,0); pos=(0,0) gives 0x41 and pos=(8,0) gives 0x42, each 1 cycle later.
REQ-039 Cursor at (79,59), send 0x41 -> cell 4799 = 0x41, cursor wraps to (0,0); then LF -> (0,1); CR -> (0,1); BS at x=0 -> (0,1).
REQ-040 Send FF mid-stream with wr_valid held -> wr_ready=0 for 4800 cycles, no further codes accepted, cursor (0,0) afterward.
REQ-041 pos_x=640 or pos_y=480 -> character=0x20; pulse resetn low at clear address 2000 -> clear restarts, 4800 more cycles.
REQ-042 Random wr_valid bursts with a scoreboard model -> RAM contents and cursor match the model every cycle.
